fam_lsu: RTL

Parametrised load/store stage succeeding the combined execute/memory stage. It sits after the ALU and takes one resolved memory operation per accept: address, store data, width, sign and destination register. It talks to data memory over a variable-latency req/gnt/rvalid handshake and returns one register-file write record per accepted operation. Over the previous stage it adds DATA_W generalisation (32/64), byte-lane alignment for loads and stores, a misalignment/illegal-width check, a memory timeout, and a pipeline flush that drains an in-flight load.

---
 rtl/fam_lsu_pkg.sv | 26 ++
 rtl/fam_lsu_align.sv | 63 ++++++
 rtl/fam_lsu.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fam_lsu_pkg.sv
// fam_lsu shared types: access widths, exception codes, FSM states.
// Imported by the LSU top and its lane-alignment helper.
package fam_pkg;

    typedef enum logic [1:0] {
        W_BYTE  = 2'd0,
        W_HALF  = 2'd1,
        W_WORD  = 2'd2,
        W_DWORD = 2'd3
    } width_e;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_TIMEOUT  = 2'd2,
        EXC_ILLEGAL  = 2'd3
    } exc_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/fam_lsu_align.sv
// Byte-lane alignment: store enables/shift, load shift and extension,
// plus alignment and width legality for the current access.
module fam_lsu_align
    import fam_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [1:0]          width,
    input  logic                sign,
    input  logic [OFF_W-1:0]    off,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata,
    output logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   wdata_sh,
    output logic [DATA_W-1:0]   rdata_ext,
    output logic                misalign,
    output logic                illegal
);
    localparam int NB = DATA_W / 8;

    logic [NB-1:0]     be_base;
    logic [OFF_W+2:0]  bit_off;
    logic [DATA_W-1:0] rsh;
    logic [63:0]       r64;
    logic [63:0]       ext;

    assign bit_off   = {off, 3'b000};
    assign wdata_sh  = wdata << bit_off;
    assign rsh       = rdata >> bit_off;
    assign r64       = 64'(rsh);
    assign be        = be_base << off;
    assign illegal   = (width == W_DWORD) && (DATA_W == 32);
    assign rdata_ext = ext[DATA_W-1:0];

    // Extension is done at 64 bits so both datapath widths share one path.
    always_comb begin
        be_base  = '0;
        ext      = r64;
        misalign = 1'b0;
        unique case (width)
            W_BYTE: begin
                be_base = NB'(8'h01);
                ext     = {{56{sign & r64[7]}}, r64[7:0]};
            end
            W_HALF: begin
                be_base  = NB'(8'h03);
                ext      = {{48{sign & r64[15]}}, r64[15:0]};
                misalign = off[0];
            end
            W_WORD: begin
                be_base  = NB'(8'h0F);
                ext      = {{32{sign & r64[31]}}, r64[31:0]};
                misalign = (off[1:0] != 2'b00);
            end
            W_DWORD: begin
                be_base  = '1;
                misalign = (off != '0);
            end
        endcase
    end

endmodule

// File: rtl/fam_lsu.sv
// Load/store stage: one memory op per accept over req/gnt/rvalid,
// with alignment checks, timeout abort and flush draining.
module fam_lsu
    import fam_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_num,
    input  logic                in_load,
    input  logic                in_store,
    input  logic                in_sign,
    input  logic [1:0]          in_width,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic                in_rfwe,
    input  logic [4:0]          in_rd,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                out_valid,
    output logic                out_num,
    output logic                out_rfwe,
    output logic [4:0]          out_rfwaddr,
    output logic [DATA_W-1:0]   out_rfwdata,
    output logic [1:0]          out_exc
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e              state;
    logic [CNT_W-1:0]    cnt;
    logic                r_load;
    logic                r_sign;
    logic                r_rfwe;
    logic [1:0]          r_width;
    logic [OFF_W-1:0]    r_off;

    logic                idle;
    logic                accept;
    logic                is_mem;
    logic                tmo;
    logic [1:0]          a_width;
    logic                a_sign;
    logic [OFF_W-1:0]    a_off;
    logic [DATA_W/8-1:0] a_be;
    logic [DATA_W-1:0]   a_wdata;
    logic [DATA_W-1:0]   a_rdata;
    logic                a_mis;
    logic                a_ill;

    assign idle     = (state == IDLE);
    assign in_ready = idle;
    assign accept   = in_valid && idle && !flush;
    assign is_mem   = in_load || in_store;
    assign tmo      = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));

    // Aligner sees the incoming op in IDLE and the latched op afterwards.
    assign a_width = idle ? in_width : r_width;
    assign a_sign  = idle ? in_sign : r_sign;
    assign a_off   = idle ? in_addr[OFF_W-1:0] : r_off;

    fam_lsu_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_align (
        .width     (a_width),
        .sign      (a_sign),
        .off       (a_off),
        .wdata     (in_wdata),
        .rdata     (mem_rdata),
        .be        (a_be),
        .wdata_sh  (a_wdata),
        .rdata_ext (a_rdata),
        .misalign  (a_mis),
        .illegal   (a_ill)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            r_load      <= 1'b0;
            r_sign      <= 1'b0;
            r_rfwe      <= 1'b0;
            r_width     <= '0;
            r_off       <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            out_valid   <= 1'b0;
            out_num     <= 1'b0;
            out_rfwe    <= 1'b0;
            out_rfwaddr <= '0;
            out_rfwdata <= '0;
            out_exc     <= EXC_NONE;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        out_num     <= in_num;
                        out_rfwaddr <= in_rd;
                        if (!is_mem) begin
                            out_valid   <= 1'b1;
                            out_rfwe    <= in_rfwe;
                            out_rfwdata <= in_wdata;
                            out_exc     <= EXC_NONE;
                        end else if (a_ill || a_mis) begin
                            out_valid   <= 1'b1;
                            out_rfwe    <= 1'b0;
                            out_rfwdata <= '0;
                            out_exc     <= a_ill ? EXC_ILLEGAL : EXC_MISALIGN;
                        end else begin
                            state     <= REQ;
                            cnt       <= '0;
                            r_load    <= in_load;
                            r_sign    <= in_sign;
                            r_rfwe    <= in_rfwe;
                            r_width   <= in_width;
                            r_off     <= in_addr[OFF_W-1:0];
                            mem_req   <= 1'b1;
                            mem_we    <= !in_load;
                            mem_be    <= a_be;
                            mem_addr  <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata <= in_load ? '0 : a_wdata;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (flush || mem_gnt || tmo) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end
                    if (flush) begin
                        state <= (mem_gnt && r_load) ? DRAIN : IDLE;
                    end else if (mem_gnt) begin
                        if (r_load) begin
                            state <= WAIT;
                        end else begin
                            state       <= IDLE;
                            out_valid   <= 1'b1;
                            out_rfwe    <= 1'b0;
                            out_rfwdata <= '0;
                            out_exc     <= EXC_NONE;
                        end
                    end else if (tmo) begin
                        state       <= IDLE;
                        out_valid   <= 1'b1;
                        out_rfwe    <= 1'b0;
                        out_rfwdata <= '0;
                        out_exc     <= EXC_TIMEOUT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (flush) begin
                        state <= mem_rvalid ? IDLE : DRAIN;
                    end else if (mem_rvalid) begin
                        state       <= IDLE;
                        out_valid   <= 1'b1;
                        out_rfwe    <= r_rfwe;
                        out_rfwdata <= a_rdata;
                        out_exc     <= EXC_NONE;
                    end else if (tmo) begin
                        state       <= IDLE;
                        out_valid   <= 1'b1;
                        out_rfwe    <= 1'b0;
                        out_rfwdata <= '0;
                        out_exc     <= EXC_TIMEOUT;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (mem_rvalid || tmo) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
